// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO of arbitrary depth with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush (clr). Asynchronous active-low reset on rst.
// Optional feature macro: FIFO_FWFT_EN (first-word fall-through read port).
// With the macro undefined, rd_data is registered and updates one cycle after
// an accepted read.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 12,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         o_fifo_full,
  output logic                         o_fifo_empty,
  output logic                         o_almost_full,
  output logic                         o_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_overflow,
  output logic                         o_underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Thresholds clamped into 0..DEPTH so they always fit the count width.
  localparam int AF_LEVEL = (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;
  localparam int AE_LEVEL = (AE_MARGIN >= DEPTH) ? DEPTH : AE_MARGIN;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  rd_acc, wr_acc;

  // Pointer advance with explicit wrap at DEPTH-1 (depth need not be 2^n).
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Accept decisions; clr suppresses both so it can't race a transfer.
  always_comb begin
    rd_acc = rd_en & ~empty & ~clr;
    wr_acc = wr_en & (~full | rd_acc) & ~clr;
  end

  // Next-state for pointers, count and sticky error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en && !wr_acc) overflow_d  = 1'b1;
      if (rd_en && !rd_acc) underflow_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef FIFO_FWFT_EN
  // Head entry is visible whenever the FIFO holds data; rd_en only pops it.
  always_comb begin
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
  end
`else
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Registered read port: load the head word on an accepted read, else hold.
  always_comb begin
    rd_data_d = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
  end

  // Read data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= '0;
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
`endif

  assign o_fifo_full    = full;
  assign o_fifo_empty   = empty;
  assign o_almost_full  = (count_q >= CW'(AF_LEVEL));
  assign o_almost_empty = (count_q <= CW'(AE_LEVEL));
  assign o_count        = count_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-based reference model of sync_fifo_param with
// directed scenarios (literal expectations) followed by randomized traffic.
// Works in both the default build and with FIFO_FWFT_EN defined.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 12;
  localparam int AFM   = 2;
  localparam int AEM   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, rd_en;
  logic [DW-1:0] wr_data, rd_data;
  logic          o_fifo_full, o_fifo_empty, o_almost_full, o_almost_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow, o_underflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_rd;

  sync_fifo_param #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_MARGIN (AFM),
    .AE_MARGIN (AEM)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .o_fifo_full   (o_fifo_full),
    .o_fifo_empty  (o_fifo_empty),
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_rd  = '0;
  endfunction

  // One clock edge of FIFO behaviour, from the pre-edge occupancy.
  function automatic void model_edge(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    bit was_full, was_empty, racc, wacc;
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    if (c) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      racc = r && !was_empty;
      wacc = w && (!was_full || racc);
      if (racc) m_rd = q.pop_front();
      if (wacc) q.push_back(d);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_unf = 1'b1;
    end
  endfunction

  // Compare every DUT output against the model.
  function automatic void compare_all();
    int sz;
    logic [DW-1:0] exp_rd;
    sz = q.size();
`ifdef FIFO_FWFT_EN
    exp_rd = (sz != 0) ? q[0] : '0;
`else
    exp_rd = m_rd;
`endif
    chk("count",     32'(o_count),      32'(sz));
    chk("full",      32'(o_fifo_full),  32'(sz == DEPTH));
    chk("empty",     32'(o_fifo_empty), 32'(sz == 0));
    chk("almost_full",  32'(o_almost_full),  32'(sz >= DEPTH - AFM));
    chk("almost_empty", 32'(o_almost_empty), 32'(sz <= AEM));
    chk("overflow",  32'(o_overflow),   32'(m_ovf));
    chk("underflow", 32'(o_underflow),  32'(m_unf));
    chk("rd_data",   32'(rd_data),      32'(exp_rd));
  endfunction

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
    wr_en = w; wr_data = d; rd_en = r; clr = c;
    @(posedge clk);
    model_edge(w, d, r, c);
    #1;
    compare_all();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  // Read (optionally with a write) and check the word returned by that read.
  task automatic xfer(input bit w, input logic [DW-1:0] d, input string name, input logic [DW-1:0] val);
`ifdef FIFO_FWFT_EN
    chk(name, 32'(rd_data), 32'(val));
    step(w, d, 1'b1, 1'b0);
`else
    step(w, d, 1'b1, 1'b0);
    chk(name, 32'(rd_data), 32'(val));
`endif
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    #2;
    model_reset();
    compare_all();
    chk("rst_empty", 32'(o_fifo_empty),   32'd1);
    chk("rst_full",  32'(o_fifo_full),    32'd0);
    chk("rst_count", 32'(o_count),        32'd0);
    chk("rst_ae",    32'(o_almost_empty), 32'd1);
    chk("rst_af",    32'(o_almost_full),  32'd0);
    chk("rst_rd",    32'(rd_data),        32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic write three / read three
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h28, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("t1_count3", 32'(o_count), 32'd3);
    xfer(1'b0, 8'h00, "t1_rd0", 8'h34);
    xfer(1'b0, 8'h00, "t1_rd1", 8'h28);
    xfer(1'b0, 8'h00, "t1_rd2", 8'hAB);
    chk("t1_count0", 32'(o_count), 32'd0);
    chk("t1_empty",  32'(o_fifo_empty), 32'd1);

    // Fill to full, almost_full threshold, overflow
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 8) chk("t2_af_at9",  32'(o_almost_full), 32'd0);
      if (i == 9) chk("t2_af_at10", 32'(o_almost_full), 32'd1);
    end
    chk("t2_full", 32'(o_fifo_full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t2_ovf",     32'(o_overflow), 32'd1);
    chk("t2_count12", 32'(o_count),    32'd12);

    // Simultaneous read+write on full, then drain through the wrap
    xfer(1'b1, 8'hEE, "t3_rd_head", 8'h00);
    chk("t3_count12", 32'(o_count), 32'd12);
    for (int i = 1; i < DEPTH; i++) xfer(1'b0, 8'h00, "t3_drain", 8'(i));
    xfer(1'b0, 8'h00, "t3_wrap", 8'hEE);
    chk("t3_empty", 32'(o_fifo_empty), 32'd1);

    // Write+read on empty: write accepted, read rejected
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("t4_unf",    32'(o_underflow), 32'd1);
    chk("t4_count1", 32'(o_count),     32'd1);
    chk("t4_ovf_sticky", 32'(o_overflow), 32'd1);
    xfer(1'b0, 8'h00, "t4_rd", 8'h5A);

    // Flush with a concurrent write
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("t5_count5", 32'(o_count), 32'd5);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    chk("t5_count0", 32'(o_count),     32'd0);
    chk("t5_empty",  32'(o_fifo_empty), 32'd1);
    chk("t5_ovf",    32'(o_overflow),  32'd0);
    chk("t5_unf",    32'(o_underflow), 32'd0);

    // Reset mid-stream discards contents
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    async_reset();
    chk("rst2_count", 32'(o_count), 32'd0);
    chk("rst2_empty", 32'(o_fifo_empty), 32'd1);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    xfer(1'b0, 8'h00, "rst2_first", 8'hA1);

`ifdef FIFO_FWFT_EN
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("t6_fwft_rd",    32'(rd_data),      32'h77);
    chk("t6_fwft_empty", 32'(o_fifo_empty), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_fwft_rd0",   32'(rd_data),      32'd0);
    chk("t6_fwft_empty1", 32'(o_fifo_empty), 32'd1);
`endif

    // Randomized traffic with phase-biased fill/drain, rare flush and reset
    for (int i = 0; i < 3000; i++) begin
      int pw;
      bit w, r, c;
      pw = ((i / 150) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(0, 99) < pw);
      r  = ($urandom_range(0, 99) < 100 - pw);
      c  = ($urandom_range(0, 199) == 0);
      if (i % 900 == 450) async_reset();
      else step(w, 8'($urandom_range(0, 255)), r, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
